rand_share_arb: RTL

Shares one 8-bit LCG random source between N_REQ requesters, for example several dice/roller displays on the board. Arbitration is round-robin. A granted requester receives one 4-bit draw, which is held with a valid/ack handshake until the requester accepts it, drops its request, or the hold times out. The LCG free-runs every clock, so a draw's value depends on the cycle it is taken.

---
 rtl/rand_share_arb.sv | 137 +++++++++++++
 1 files changed

// File: rtl/rand_share_arb.sv
// rand_share_arb: shares one free-running 8-bit LCG between N_REQ requesters.
// Requesters are served round-robin. Each grant yields one 4-bit draw. The draw
// is held with a valid/ack handshake until the owner accepts it, the owner drops
// its request, or the hold times out.
//
// Ports:
//   i_clk      clock
//   i_rst      asynchronous, active-low reset
//   i_req      per-requester draw request (level, held until served)
//   i_ack      per-requester accept; only the granted bit is looked at in HOLD
//   o_grant    one-hot owner of the current draw, 0 when idle
//   o_valid    o_number is valid for the o_grant owner
//   o_number   drawn value, lcg[5:2] at the DRAW edge, kept after release
//   o_busy     arbiter is not idle
//   o_timeout  one-cycle pulse when a hold is released by timeout only
module rand_share_arb #(
    parameter int         N_REQ   = 4,
    parameter logic [7:0] SEED    = 8'd17,
    parameter logic [7:0] INC     = 8'd3,
    parameter int         TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_ack,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_valid,
    output logic [3:0]       o_number,
    output logic             o_busy,
    output logic             o_timeout
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    logic [7:0]      lcg;
    logic [7:0]      lcg_next;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gidx;
    logic [TW-1:0]   timer;

    logic            sel_found;
    logic [PW-1:0]   sel_idx;
    logic [N_REQ-1:0] sel_onehot;

    logic            rel_ack;
    logic            rel_abandon;
    logic            rel_tmo;

    // (base + off) mod N_REQ for off in 0..N_REQ.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return PW'(s);
    endfunction

    // x*5 as a shift-add; every term wraps at 8 bits.
    assign lcg_next = (lcg << 2) + lcg + INC;

    // Round-robin search: first requesting index starting at ptr, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!sel_found && i_req[wrap_add(ptr, i)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_add(ptr, i);
            end
        end
        sel_onehot[sel_idx] = 1'b1;
    end

    assign rel_ack     = i_ack[gidx];
    assign rel_abandon = ~i_req[gidx];
    assign rel_tmo     = (timer == TW'(TIMEOUT - 1));

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            lcg       <= SEED;
            state     <= IDLE;
            ptr       <= '0;
            gidx      <= '0;
            timer     <= '0;
            o_grant   <= '0;
            o_valid   <= 1'b0;
            o_number  <= 4'd0;
            o_busy    <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            lcg       <= lcg_next;
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        o_grant <= sel_onehot;
                        gidx    <= sel_idx;
                        o_busy  <= 1'b1;
                        state   <= DRAW;
                    end
                end
                DRAW: begin
                    // Uses the pre-update LCG value at this edge.
                    o_number <= lcg[5:2];
                    o_valid  <= 1'b1;
                    timer    <= '0;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (rel_ack || rel_abandon || rel_tmo) begin
                        o_valid   <= 1'b0;
                        o_grant   <= '0;
                        o_busy    <= 1'b0;
                        ptr       <= wrap_add(gidx, 1);
                        // Ack or abandon on the timeout edge is a normal release.
                        o_timeout <= rel_tmo & ~rel_ack & ~rel_abandon;
                        state     <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
